// File: rtl/uart_fifo_core.sv
// uart_fifo_core: UART core with programmable baud-tick divider, OSR oversampling,
// TX/RX FIFOs with valid/ready handshakes, per-frame RX error flags and a
// sticky overrun flag. ctrl_word: [1:0] data bits-5, [2] even parity,
// [3] parity disabled, [4] long stop.
// Optional build macro: UART_MAJORITY_EN selects 2-of-3 majority RX sampling
// (centre-1, centre, centre+1); otherwise one sample at the centre tick.
module uart_fifo_core #(
  parameter int OSR        = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 12,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [4:0]       ctrl_word,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_out,
  output logic             tx_busy,
  output logic [LVL_W-1:0] tx_level,
  input  logic             rx_in,
  output logic [7:0]       rx_data,
  output logic             rx_frame_err,
  output logic             rx_parity_err,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [LVL_W-1:0] rx_level,
  output logic             rx_overrun,
  input  logic             rx_ovr_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(2 * OSR) + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PAR = 3'd3, S_STOP = 3'd4
  } state_t;

  // Even parity is the XOR of the active data bits, odd parity its inverse.
  function automatic logic calc_parity(input logic [7:0] data, input logic [1:0] len, input logic even);
    logic [7:0] mask;
    case (len)
      2'd0:    mask = 8'h1F;
      2'd1:    mask = 8'h3F;
      2'd2:    mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
    calc_parity = even ? ^(data & mask) : ~(^(data & mask));
  endfunction

  // ---------------- baud tick ----------------
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_s;

  // Tick generator: >= lets the counter recover at once if baud_div shrinks.
  always_comb begin
    tick_s = (div_q >= baud_div);
    if (tick_s) div_d = '0;
    else        div_d = div_q + DIV_W'(1);
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]       tx_mem_q [FIFO_DEPTH];
  logic [AW-1:0]    tx_wr_q, tx_rd_q;
  logic [LVL_W-1:0] tx_cnt_q, tx_cnt_d;
  logic             tx_push_s, tx_pop_s, tx_load_s, tx_empty_s;
  logic [7:0]       tx_head_s;

  assign tx_ready   = (tx_cnt_q != LVL_W'(FIFO_DEPTH));
  assign tx_push_s  = tx_valid && tx_ready;
  assign tx_empty_s = (tx_cnt_q == '0);
  assign tx_head_s  = tx_mem_q[tx_rd_q];
  assign tx_level   = tx_cnt_q;

  // TX occupancy: simultaneous push and pop cancel.
  always_comb begin
    tx_cnt_d = tx_cnt_q;
    if (tx_push_s && !tx_pop_s)      tx_cnt_d = tx_cnt_q + LVL_W'(1);
    else if (!tx_push_s && tx_pop_s) tx_cnt_d = tx_cnt_q - LVL_W'(1);
    else                             tx_cnt_d = tx_cnt_q;
  end

  // ---------------- TX FSM ----------------
  state_t        tx_state_q, tx_state_d;
  logic [TW-1:0] tx_tcnt_q, tx_tcnt_d, tx_stop_len_s;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic [1:0]    tx_len_q, tx_len_d;
  logic          tx_nopar_q, tx_nopar_d, tx_long_q, tx_long_d, tx_par_q, tx_par_d;
  logic          tx_out_q, tx_out_d, tx_busy_q, tx_busy_d;
  logic          tx_bit_end_s, tx_stop_end_s, tx_last_s;

  assign tx_stop_len_s = !tx_long_q ? TW'(OSR) : ((tx_len_q == 2'd0) ? TW'(OSR * 3 / 2) : TW'(2 * OSR));
  assign tx_bit_end_s  = tick_s && (tx_tcnt_q == TW'(OSR - 1));
  assign tx_stop_end_s = tick_s && (tx_tcnt_q == tx_stop_len_s - TW'(1));
  assign tx_last_s     = (tx_bit_q == ({1'b0, tx_len_q} + 3'd4));

  // TX next state: bit sequencing; a frame is loaded from IDLE or straight out of STOP.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_len_d   = tx_len_q;
    tx_nopar_d = tx_nopar_q;
    tx_long_d  = tx_long_q;
    tx_par_d   = tx_par_q;
    tx_load_s  = 1'b0;
    tx_pop_s   = 1'b0;
    if (tx_state_q != S_IDLE && tick_s) tx_tcnt_d = tx_tcnt_q + TW'(1);
    else                                tx_tcnt_d = tx_tcnt_q;
    case (tx_state_q)
      S_IDLE: begin
        if (!tx_empty_s) tx_load_s = 1'b1;
        else             tx_load_s = 1'b0;
      end
      S_START: begin
        if (tx_bit_end_s) begin
          tx_state_d = S_DATA;
          tx_tcnt_d  = '0;
          tx_bit_d   = 3'd0;
        end else begin
          tx_state_d = S_START;
        end
      end
      S_DATA: begin
        if (tx_bit_end_s) begin
          tx_tcnt_d  = '0;
          tx_shift_d = tx_shift_q >> 1;
          if (tx_last_s) tx_state_d = tx_nopar_q ? S_STOP : S_PAR;
          else           tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_state_d = S_DATA;
        end
      end
      S_PAR: begin
        if (tx_bit_end_s) begin
          tx_state_d = S_STOP;
          tx_tcnt_d  = '0;
        end else begin
          tx_state_d = S_PAR;
        end
      end
      S_STOP: begin
        if (tx_stop_end_s) begin
          tx_tcnt_d = '0;
          if (!tx_empty_s) tx_load_s  = 1'b1;
          else             tx_state_d = S_IDLE;
        end else begin
          tx_state_d = S_STOP;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
    if (tx_load_s) begin
      tx_pop_s   = 1'b1;
      tx_state_d = S_START;
      tx_tcnt_d  = '0;
      tx_shift_d = tx_head_s;
      tx_len_d   = ctrl_word[1:0];
      tx_nopar_d = ctrl_word[3];
      tx_long_d  = ctrl_word[4];
      tx_par_d   = calc_parity(tx_head_s, ctrl_word[1:0], ctrl_word[2]);
    end else begin
      tx_pop_s = 1'b0;
    end
  end

  // TX outputs decoded from the next state so the pins come straight from flops.
  always_comb begin
    tx_out_d = 1'b1;
    case (tx_state_d)
      S_START: tx_out_d = 1'b0;
      S_DATA:  tx_out_d = tx_shift_d[0];
      S_PAR:   tx_out_d = tx_par_d;
      default: tx_out_d = 1'b1;
    endcase
    tx_busy_d = (tx_state_d != S_IDLE) || (tx_cnt_d != '0);
  end

  assign tx_out  = tx_out_q;
  assign tx_busy = tx_busy_q;

  // ---------------- RX path ----------------
  logic rx_meta_q, rx_s_q, rx_prev_q, rx_fall_s, rx_smp_s;
`ifdef UART_MAJORITY_EN
  logic [1:0] hist_q;
  assign rx_smp_s = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
  logic hist_q;
  assign rx_smp_s = hist_q;
`endif
  assign rx_fall_s = rx_prev_q && !rx_s_q;

  state_t        rx_state_q, rx_state_d;
  logic [TW-1:0] rx_ph_q, rx_ph_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_dat_q, rx_dat_d;
  logic [3:0]    rx_ctrl_q, rx_ctrl_d;
  logic          rx_perr_q, rx_perr_d, rx_ferr_s, rx_done_s, rx_bit_end_s;

  assign rx_bit_end_s = tick_s && (rx_ph_q == TW'(OSR - 1));

  // RX next state: start qualification, centre sampling, first stop bit check.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_bit_d   = rx_bit_q;
    rx_dat_d   = rx_dat_q;
    rx_ctrl_d  = rx_ctrl_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_s  = 1'b0;
    rx_done_s  = 1'b0;
    if (rx_state_q != S_IDLE && tick_s) rx_ph_d = rx_ph_q + TW'(1);
    else                                rx_ph_d = rx_ph_q;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_fall_s) begin
          rx_state_d = S_START;
          rx_ctrl_d  = ctrl_word[3:0];
          rx_ph_d    = '0;
          rx_bit_d   = 3'd0;
          rx_dat_d   = 8'h00;
          rx_perr_d  = 1'b0;
        end else begin
          rx_state_d = S_IDLE;
        end
      end
      S_START: begin
        if (tick_s && rx_ph_q == TW'(OSR / 2)) begin
          rx_ph_d    = '0;
          rx_state_d = rx_smp_s ? S_IDLE : S_DATA;
        end else begin
          rx_state_d = S_START;
        end
      end
      S_DATA: begin
        if (rx_bit_end_s) begin
          rx_ph_d            = '0;
          rx_dat_d[rx_bit_q] = rx_smp_s;
          if (rx_bit_q == ({1'b0, rx_ctrl_q[1:0]} + 3'd4)) rx_state_d = rx_ctrl_q[3] ? S_STOP : S_PAR;
          else                                             rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_state_d = S_DATA;
        end
      end
      S_PAR: begin
        if (rx_bit_end_s) begin
          rx_ph_d    = '0;
          rx_perr_d  = rx_smp_s ^ calc_parity(rx_dat_q, rx_ctrl_q[1:0], rx_ctrl_q[2]);
          rx_state_d = S_STOP;
        end else begin
          rx_state_d = S_PAR;
        end
      end
      S_STOP: begin
        if (rx_bit_end_s) begin
          rx_done_s  = 1'b1;
          rx_ferr_s  = !rx_smp_s;
          rx_state_d = S_IDLE;
        end else begin
          rx_state_d = S_STOP;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [9:0]       rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0]    rx_wr_q, rx_rd_q;
  logic [LVL_W-1:0] rx_cnt_q, rx_cnt_d;
  logic             rx_full_s, rx_push_s, rx_pop_s, rx_ovr_q, rx_ovr_d;
  logic [9:0]       rx_head_s;

  assign rx_full_s = (rx_cnt_q == LVL_W'(FIFO_DEPTH));
  assign rx_valid  = (rx_cnt_q != '0);
  assign rx_pop_s  = rx_valid && rx_ready;
  assign rx_push_s = rx_done_s && (!rx_full_s || rx_pop_s);
  assign rx_head_s = rx_valid ? rx_mem_q[rx_rd_q] : 10'h000;
  assign rx_data       = rx_head_s[7:0];
  assign rx_frame_err  = rx_head_s[8];
  assign rx_parity_err = rx_head_s[9];
  assign rx_level      = rx_cnt_q;
  assign rx_overrun    = rx_ovr_q;

  // RX occupancy and sticky overrun; a new overrun beats a same-cycle clear.
  always_comb begin
    rx_cnt_d = rx_cnt_q;
    if (rx_push_s && !rx_pop_s)      rx_cnt_d = rx_cnt_q + LVL_W'(1);
    else if (!rx_push_s && rx_pop_s) rx_cnt_d = rx_cnt_q - LVL_W'(1);
    else                             rx_cnt_d = rx_cnt_q;
    if (rx_done_s && !rx_push_s) rx_ovr_d = 1'b1;
    else if (rx_ovr_clr)         rx_ovr_d = 1'b0;
    else                         rx_ovr_d = rx_ovr_q;
  end

  // FIFO storage arrays; contents need no reset as the levels gate visibility.
  always_ff @(posedge clk) begin
    if (tx_push_s) tx_mem_q[tx_wr_q] <= tx_data;
    if (rx_push_s) rx_mem_q[rx_wr_q] <= {rx_perr_q, rx_ferr_s, rx_dat_q};
  end

  // All control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_cnt_q   <= '0;
      tx_state_q <= S_IDLE;
      tx_tcnt_q  <= '0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_len_q   <= 2'd0;
      tx_nopar_q <= 1'b0;
      tx_long_q  <= 1'b0;
      tx_par_q   <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_busy_q  <= 1'b0;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      hist_q     <= '1;
      rx_state_q <= S_IDLE;
      rx_ph_q    <= '0;
      rx_bit_q   <= 3'd0;
      rx_dat_q   <= 8'h00;
      rx_ctrl_q  <= 4'h0;
      rx_perr_q  <= 1'b0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_cnt_q   <= '0;
      rx_ovr_q   <= 1'b0;
    end else begin
      div_q      <= div_d;
      tx_wr_q    <= tx_push_s ? tx_wr_q + AW'(1) : tx_wr_q;
      tx_rd_q    <= tx_pop_s ? tx_rd_q + AW'(1) : tx_rd_q;
      tx_cnt_q   <= tx_cnt_d;
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_len_q   <= tx_len_d;
      tx_nopar_q <= tx_nopar_d;
      tx_long_q  <= tx_long_d;
      tx_par_q   <= tx_par_d;
      tx_out_q   <= tx_out_d;
      tx_busy_q  <= tx_busy_d;
      rx_meta_q  <= rx_in;
      rx_s_q     <= rx_meta_q;
      rx_prev_q  <= rx_s_q;
`ifdef UART_MAJORITY_EN
      hist_q     <= tick_s ? {hist_q[0], rx_s_q} : hist_q;
`else
      hist_q     <= tick_s ? rx_s_q : hist_q;
`endif
      rx_state_q <= rx_state_d;
      rx_ph_q    <= rx_ph_d;
      rx_bit_q   <= rx_bit_d;
      rx_dat_q   <= rx_dat_d;
      rx_ctrl_q  <= rx_ctrl_d;
      rx_perr_q  <= rx_perr_d;
      rx_wr_q    <= rx_push_s ? rx_wr_q + AW'(1) : rx_wr_q;
      rx_rd_q    <= rx_pop_s ? rx_rd_q + AW'(1) : rx_rd_q;
      rx_cnt_q   <= rx_cnt_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end
endmodule

// File: tb/tb_uart_fifo_core.sv
// Scoreboard bench for uart_fifo_core: expected RX entries are queued when
// frames are issued; an independent monitor pops and compares on every RX pop.
module tb_uart_fifo_core;
  localparam int OSR = 16, DEPTH = 8, DIV_W = 12, LW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DIV_W-1:0] baud_div = '0;
  logic [4:0] ctrl_word = 5'b01000;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0, rx_ready = 1'b0, rx_ovr_clr = 1'b0;
  logic loop_en = 1'b0, rx_drv = 1'b1, rand_ready = 1'b0;
  logic tx_ready, tx_out, tx_busy, rx_frame_err, rx_parity_err, rx_valid, rx_overrun;
  logic [LW-1:0] tx_level, rx_level;
  logic [7:0] rx_data;
  logic rx_in;
  assign rx_in = loop_en ? tx_out : rx_drv;

  int total = 0;
  int bad = 0;
  logic [9:0] exp_q[$];

  uart_fifo_core #(.OSR(OSR), .FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .ctrl_word(ctrl_word),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_out(tx_out),
    .tx_busy(tx_busy), .tx_level(tx_level), .rx_in(rx_in), .rx_data(rx_data),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_level(rx_level), .rx_overrun(rx_overrun), .rx_ovr_clr(rx_ovr_clr));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk); #1;
    if (rand_ready) rx_ready = ($urandom_range(0, 3) != 0);
  endtask

  function automatic logic [7:0] dmask(input logic [4:0] c);
    int n;
    n = int'(c[1:0]) + 5;
    return 8'((1 << n) - 1);
  endfunction

  function automatic logic par_bit(input logic [7:0] d, input logic [4:0] c);
    int ones;
    ones = $countones(d & dmask(c));
    return c[2] ? ((ones % 2) != 0) : ((ones % 2) == 0);
  endfunction

  task automatic send(input logic [7:0] d, input bit expect_it);
    int n;
    n = 0;
    while (!tx_ready && n < 20000) begin cyc(); n++; end
    chk("tx_ready_wait", tx_ready, 1);
    tx_data = d; tx_valid = 1'b1;
    cyc();
    tx_valid = 1'b0;
    if (expect_it) exp_q.push_back({2'b00, d & dmask(ctrl_word)});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (tx_busy && n < 40000) begin cyc(); n++; end
    chk("tx_idle_wait", tx_busy, 0);
    repeat (3 * OSR * (int'(baud_div) + 1) + 20) cyc();
  endtask

  task automatic drain();
    int n;
    rand_ready = 1'b0; rx_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 40000) begin cyc(); n++; end
    chk("drain_empty", exp_q.size(), 0);
    cyc();
  endtask

  // Compare tx_out every cycle against a frame built from the framing rules (baud_div=0).
  task automatic check_wave(input logic [7:0] d);
    logic w[$];
    int n, stop_len;
    n = int'(ctrl_word[1:0]) + 5;
    repeat (OSR) w.push_back(1'b0);
    for (int i = 0; i < n; i++) repeat (OSR) w.push_back(d[i]);
    if (!ctrl_word[3]) repeat (OSR) w.push_back(par_bit(d, ctrl_word));
    stop_len = !ctrl_word[4] ? OSR : ((n == 5) ? OSR * 3 / 2 : 2 * OSR);
    repeat (stop_len) w.push_back(1'b1);
    send(d, loop_en);
    @(negedge clk); chk("wave_pre_start", tx_out, 1);
    foreach (w[i]) begin
      @(negedge clk);
      chk("wave_bit", tx_out, w[i]);
      chk("wave_busy", tx_busy, 1);
    end
    @(negedge clk);
    chk("wave_post_out", tx_out, 1);
    chk("wave_post_busy", tx_busy, 0);
    cyc();
  endtask

  // Drive a serial frame on rx_in; optional wrong parity, stop value and a 1-cycle glitch.
  task automatic drive_frame(input logic [7:0] d, input logic par_flip, input logic stop_v, input int gbit);
    logic b[$];
    int n;
    n = int'(ctrl_word[1:0]) + 5;
    b.push_back(1'b0);
    for (int i = 0; i < n; i++) b.push_back(d[i]);
    if (!ctrl_word[3]) b.push_back(par_bit(d, ctrl_word) ^ par_flip);
    b.push_back(stop_v);
    foreach (b[k]) begin
      for (int j = 0; j < OSR; j++) begin
        rx_drv = b[k] ^ ((k == gbit) && (j == OSR / 2));
        cyc();
      end
    end
    rx_drv = 1'b1;
    repeat (2 * OSR) cyc();
  endtask

  // Monitor: every RX pop is compared with the head of the scoreboard.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (!rst && rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          chk("rx_unexpected", {rx_parity_err, rx_frame_err, rx_data}, 10'h3FF);
        end else begin
          e = exp_q.pop_front();
          chk("rx_entry", {rx_parity_err, rx_frame_err, rx_data}, e);
        end
      end
    end
  end

  initial begin
    logic [7:0] d;
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_tx_out", tx_out, 1);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_overrun", rx_overrun, 0);
    chk("rst_levels", {tx_level, rx_level}, 0);
    chk("rst_rx_head", {rx_parity_err, rx_frame_err, rx_data}, 0);
    cyc(); rst = 1'b0; cyc();

    // 8N1 waveform of 0xA5, then 5-bit odd-parity long-stop frame.
    loop_en = 1'b1; rx_ready = 1'b1; baud_div = '0;
    ctrl_word = 5'b01000; check_wave(8'hA5);
    ctrl_word = 5'b10000; check_wave(8'h1B);
    wait_idle(); drain();

    // 7E1 loopback at baud_div=3.
    ctrl_word = 5'b00110; baud_div = 12'd3;
    send(8'h3C, 1'b1); send(8'h7F, 1'b1); send(8'h00, 1'b1);
    wait_idle(); drain();

    // Random framing, rates and data with random RX back-pressure.
    for (int bt = 0; bt < 6; bt++) begin
      ctrl_word = 5'($urandom_range(0, 31));
      baud_div = 12'($urandom_range(0, 3));
      rand_ready = 1'b1;
      for (int f = 0; f < 4; f++) send(8'($urandom_range(0, 255)), 1'b1);
      wait_idle(); drain();
    end

    // Overrun: nine frames into an eight-entry RX FIFO with no pops.
    ctrl_word = 5'b01000; baud_div = '0; rx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) send(8'(i), i <= DEPTH);
    wait_idle();
    @(negedge clk);
    chk("ovr_level", rx_level, DEPTH);
    chk("ovr_flag", rx_overrun, 1);
    chk("ovr_head", {rx_valid, rx_data}, 9'h101);
    cyc(); rx_ovr_clr = 1'b1; cyc(); rx_ovr_clr = 1'b0;
    @(negedge clk); chk("ovr_clear", rx_overrun, 0);
    cyc(); drain();
    @(negedge clk); chk("ovr_drained_level", rx_level, 0);

    // Driven 8E1 frames: wrong parity, then low stop bit.
    loop_en = 1'b0; rx_drv = 1'b1; ctrl_word = 5'b00111; repeat (5) cyc();
    exp_q.push_back({1'b1, 1'b0, 8'h55}); drive_frame(8'h55, 1'b1, 1'b1, -1);
    exp_q.push_back({1'b0, 1'b1, 8'h55}); drive_frame(8'h55, 1'b0, 1'b0, -1);
    drain();

    // Short low pulse must be rejected as a glitch.
    rx_drv = 1'b0; repeat (3) cyc(); rx_drv = 1'b1;
    repeat (80) cyc();
    @(negedge clk);
    chk("glitch_rx_level", rx_level, 0);
    chk("glitch_rx_valid", rx_valid, 0);

    // Fill the TX FIFO at a slow rate, try one extra push, then reset mid-frame.
    baud_div = 12'd100; ctrl_word = 5'b01000; cyc();
    for (int i = 0; i < 9; i++) begin
      d = 8'($urandom_range(0, 255));
      tx_data = d; tx_valid = 1'b1; cyc();
    end
    tx_valid = 1'b0;
    @(negedge clk);
    chk("full_level", tx_level, DEPTH);
    chk("full_ready", tx_ready, 0);
    chk("full_tx_low", tx_out, 0);
    cyc(); tx_data = 8'h99; tx_valid = 1'b1; cyc(); tx_valid = 1'b0;
    @(negedge clk); chk("full_no_push", tx_level, DEPTH);
    cyc(); rst = 1'b1; cyc();
    @(negedge clk);
    chk("rst_mid_tx_out", tx_out, 1);
    chk("rst_mid_level", tx_level, 0);
    chk("rst_mid_busy", tx_busy, 0);
    chk("rst_mid_ready", tx_ready, 1);
    cyc(); rst = 1'b0; baud_div = '0; repeat (5) cyc();

`ifdef UART_MAJORITY_EN
    // A one-cycle glitch at a data bit centre is out-voted.
    ctrl_word = 5'b01000;
    exp_q.push_back({2'b00, 8'hA5}); drive_frame(8'hA5, 1'b0, 1'b1, 3);
    drain();
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_fifo_core.md
Name: uart_fifo_core

Overview:
Parametrised successor of the team's fixed-16x UART core. It keeps the same 5-bit ctrl_word framing encoding and adds:
- internal programmable baud-tick divider
- configurable oversampling ratio
- TX and RX FIFOs with valid/ready handshakes
- per-frame error flags stored alongside RX data
- a sticky overrun flag

It sits between the tt_um top-level pin mapping and the serial pins and replaces the direct tx_start/baud16_en interface.

Parameters:
OSR, 16, oversampling ticks per bit; even, 8..32
FIFO_DEPTH, 8, entries per FIFO; power of 2, >=2
DIV_W, 12, width of baud_div

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
baud_div  in  DIV_W  tick period minus 1; tick every baud_div+1 clocks
ctrl_word  in  5  [1:0]=data bits-5 (5..8); [2]=1 even/0 odd parity; [3]=1 parity disabled; [4]=1 long stop
tx_data  in  8  TX FIFO write data
tx_valid  in  1  TX push request
tx_ready  out  1  TX FIFO not full
tx_out  out  1  serial output, idle high
tx_busy  out  1  TX FSM not IDLE or TX FIFO non-empty
tx_level  out  clog2(FIFO_DEPTH)+1  TX FIFO occupancy
rx_in  in  1  serial input, asynchronous
rx_data  out  8  RX FIFO head data, zero-extended above data width
rx_frame_err  out  1  head entry stop bit sampled low
rx_parity_err  out  1  head entry parity mismatch
rx_valid  out  1  RX FIFO not empty
rx_ready  in  1  RX pop request
rx_level  out  clog2(FIFO_DEPTH)+1  RX FIFO occupancy
rx_overrun  out  1  sticky; a frame was dropped because RX FIFO was full
rx_ovr_clr  in  1  clears rx_overrun

Behaviour:
Reset:
- tx_out=1; tx_busy=0; tx_ready=1; rx_valid=0; rx_overrun=0; levels=0; error outputs=0; rx_data=0.
- FIFOs emptied; tick counter=0; both FSMs IDLE.
- Reset mid-frame aborts the frame immediately; tx_out is 1 the cycle after rst is sampled.

Tick:
- Counter 0..baud_div; a one-cycle tick pulses when counter==baud_div, then counter wraps to 0.
- baud_div=0 gives a tick every clock.
- Shared by TX and RX.

Push/pop rules:
- Push occurs on clk when tx_valid&&tx_ready.
- tx_ready=!full, derived from registered state only; no bypass when full, even if TX pops the same cycle.

TX FSM (IDLE, START, DATA, PARITY, STOP):
- IDLE with FIFO non-empty: pop head, latch ctrl_word and parity, go START. tx_out goes low the next cycle.
- Each bit lasts OSR ticks. Data bits are sent LSB first, N=ctrl_word[1:0]+5.
- PARITY is skipped if ctrl_word[3]=1. Parity bit = XOR of the N data bits (even) or XNOR (odd); bits above N are ignored.
- STOP lasts OSR ticks if ctrl_word[4]=0; 2*OSR if ctrl_word[4]=1 and N>5; 3*OSR/2 if ctrl_word[4]=1 and N=5.
- From STOP, go straight to the next START (no idle bit) if FIFO is non-empty.
- ctrl_word changes mid-frame have no effect until the next frame.

RX path:
- rx_in passes through a 2-FF synchronizer; rx_s is the synchronized signal.
- IDLE: a falling edge on rx_s latches ctrl_word, enters START, and clears the tick phase counter.
- START: at tick OSR/2-1 after the edge, rx_s must be 0, else return to IDLE (glitch reject).
- Each subsequent bit is sampled at its centre: OSR ticks after the previous sample.
- Data is assembled LSB first.
- The parity check compares the received parity bit against the computed parity; mismatch sets the entry's parity_err.
- Stop sample 0 sets frame_err. RX checks the first stop bit only; then it returns to IDLE immediately, ready for the next start edge.

RX FIFO:
- 10-bit entries {parity_err, frame_err, data}; first-word-fall-through.
- Pop occurs on clk when rx_valid&&rx_ready.
- On frame completion:
  - if not full, or a pop happens the same cycle: write the entry.
  - otherwise: drop the entry and set rx_overrun.
- If rx_ovr_clr and a new overrun occur in the same cycle, the set wins.

Levels:
- Update the cycle after push/pop.
- Simultaneous push and pop leaves the level unchanged.
- Levels range 0..FIFO_DEPTH.

Optional Feature:
UART_MAJORITY_EN
- Defined: each RX sample (start, data, parity, stop) is the 2-of-3 majority of rx_s at ticks centre-1, centre, centre+1.
- Undefined: single sample at the centre tick.
- Bit timing and latency are identical in both builds.

Test Plan:
1. baud_div=0, OSR=16, ctrl=5'b01000 (8N1), push 0xA5. Required tx_out:
   - low for 16 cycles;
   - then 1,0,1,0,0,1,0,1 at 16 cycles each;
   - then high for 16 cycles;
   - tx_busy falls after stop; total frame 160 cycles.
2. Loopback tx_out→rx_in, ctrl=5'b00110 (7 bits, even parity), baud_div=3. Push 0x3C, 0x7F, 0x00. Required: RX pops 0x3C, 0x7F, 0x00 in order, all error flags 0.
3. FIFO_DEPTH=8, loopback, no pops. Send 9 frames 0x01..0x09. Required: rx_level=8, rx_overrun=1, head=0x01, 0x09 absent. Pulse rx_ovr_clr: rx_overrun returns to 0.
4. Drive 8E1 frame for 0x55 with parity bit 1 (wrong). Then drive 0x55 with a low stop bit. Required: first entry parity_err=1/frame_err=0; second entry frame_err=1.
5. baud_div=0: rx_in low for 3 cycles, then high. Required: no entry, rx_level=0. Assert rst mid-TX-frame: tx_out=1 next cycle, tx_level=0.
6. ctrl=5'b10000 (5 bits, long stop): stop lasts 24 ticks. With UART_MAJORITY_EN: a 1-cycle glitch at a data bit centre is still received correctly.
